// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and state encoding for the UART frame controller
package uart_pkg;
  localparam logic [7:0] SOF_DEFAULT = 8'hAA;
  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;
  typedef enum logic [2:0] {IDLE, CMD, LEN, DATA, CHK} state_t;
endpackage

// File: rtl/uart_frame_ctrl_if.sv
// uart_frame_ctrl_if: byte input and frame/payload output bundle of the frame controller
interface uart_frame_ctrl_if #(
  parameter int MAX_LEN = 16
);
  localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  logic [7:0] rx_data;
  logic rx_valid;
  logic [7:0] cmd_out;
  logic [7:0] len_out;
  logic [7:0] pl_data;
  logic pl_valid;
  logic [IW-1:0] pl_idx;
  logic frame_ok;
  logic frame_err;
  logic [1:0] err_code;
  logic busy;
  modport master (
    output rx_data, rx_valid,
    input cmd_out, len_out, pl_data, pl_valid, pl_idx, frame_ok, frame_err, err_code, busy
  );
  modport slave (
    input rx_data, rx_valid,
    output cmd_out, len_out, pl_data, pl_valid, pl_idx, frame_ok, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_idle_timer.sv
// uart_idle_timer: counts byte-free cycles inside a frame and flags the inter-byte timeout
module uart_idle_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input logic clk,
  input logic res,
  input logic enable,
  input logic kick,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] t;
  assign expired = enable && !kick && t == LAST;
  // a byte (kick) always beats expiry; the count restarts whenever idle, kicked or expired
  always_ff @(posedge clk)
    t <= (res || !enable || kick || expired) ? '0 : t + TW'(1);
endmodule

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: SOF/CMD/LEN/payload/checksum frame sequencer with inter-byte timeout
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE = SOF_DEFAULT,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT_CYC = 100000
) (
  input logic clk,
  input logic res,
  uart_frame_ctrl_if.slave bus
);
  localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAXL = 8'(MAX_LEN);
  state_t state;
  logic [7:0] chk;
  logic [7:0] cnt;
  logic expired;
  assign bus.busy = state != IDLE;
  uart_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk(clk),
    .res(res),
    .enable(state != IDLE),
    .kick(bus.rx_valid),
    .expired(expired)
  );
  // frame sequencer; every output is registered on the edge that samples the byte strobe
  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
      chk <= '0;
      cnt <= '0;
      bus.cmd_out <= '0;
      bus.len_out <= '0;
      bus.pl_data <= '0;
      bus.pl_valid <= 1'b0;
      bus.pl_idx <= '0;
      bus.frame_ok <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.err_code <= '0;
    end else begin
      bus.pl_valid <= 1'b0;
      bus.frame_ok <= 1'b0;
      bus.frame_err <= 1'b0;
      if (expired) begin
        bus.frame_err <= 1'b1;
        bus.err_code <= ERR_TMO;
        state <= IDLE;
      end else if (bus.rx_valid) begin
        case (state)
          IDLE: state <= bus.rx_data == SOF_BYTE ? CMD : IDLE;
          CMD: begin
            bus.cmd_out <= bus.rx_data;
            chk <= bus.rx_data;
            state <= LEN;
          end
          LEN: begin
            bus.len_out <= bus.rx_data;
            chk <= chk ^ bus.rx_data;
            cnt <= '0;
            if (bus.rx_data > MAXL) begin
              bus.frame_err <= 1'b1;
              bus.err_code <= ERR_LEN;
              state <= IDLE;
            end else begin
              state <= bus.rx_data == 8'd0 ? CHK : DATA;
            end
          end
          DATA: begin
            bus.pl_data <= bus.rx_data;
            bus.pl_valid <= 1'b1;
            bus.pl_idx <= cnt[IW-1:0];
            chk <= chk ^ bus.rx_data;
            cnt <= cnt + 8'd1;
            state <= cnt == bus.len_out - 8'd1 ? CHK : DATA;
          end
          CHK: begin
            bus.frame_ok <= bus.rx_data == chk;
            bus.frame_err <= bus.rx_data != chk;
            if (bus.rx_data != chk) bus.err_code <= ERR_CHK;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb_uart_frame_ctrl: scoreboard bench for the UART frame controller
module tb_uart_frame_ctrl;
  import uart_pkg::*;
  localparam int TMO = 40;
  logic clk = 1'b0;
  logic res = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [13:0] exp_q[$];
  logic [13:0] got;
  logic [13:0] want;
  uart_frame_ctrl_if #(.MAX_LEN(16)) bus ();
  uart_frame_ctrl #(.SOF_BYTE(8'hAA), .MAX_LEN(16), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  always @(negedge clk) begin
    if (bus.frame_ok && bus.frame_err) begin
      checks++;
      errors++;
      $display("FAIL pulse_excl: frame_ok=1 frame_err=1 required at most one");
    end
    if (bus.pl_valid || bus.frame_ok || bus.frame_err) begin
      got = bus.pl_valid ? {2'd0, bus.pl_data, bus.pl_idx} :
            bus.frame_ok ? {2'd1, 12'h000} : {2'd2, 6'h00, bus.err_code, 4'h0};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: got event %h required none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL scoreboard: got event %h required %h", got, want);
        end
      end
    end
  end
  function automatic void push_pl(input logic [7:0] d, input logic [3:0] i);
    exp_q.push_back({2'd0, d, i});
  endfunction
  function automatic void push_ok();
    exp_q.push_back({2'd1, 12'h000});
  endfunction
  function automatic void push_err(input logic [1:0] c);
    exp_q.push_back({2'd2, 6'h00, c, 4'h0});
  endfunction
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
  endtask
  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
  endtask
  task automatic sendg(input logic [7:0] b);
    send(b);
    gap(1);
  endtask
  task automatic drain(input string name);
    gap(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d events outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset;
    res = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cmd_out, bus.len_out, bus.pl_data, bus.pl_valid, bus.pl_idx, bus.frame_ok,
         bus.frame_err, bus.err_code, bus.busy} !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs: cmd=%h len=%h pl=%h busy=%b required all 0",
               bus.cmd_out, bus.len_out, bus.pl_data, bus.busy);
    end
    res = 1'b0;
    gap(2);
  endtask
  task automatic test_good_frame;
    sendg(8'hAA);
    sendg(8'h01);
    sendg(8'h02);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL good_busy: busy=%b required 1", bus.busy);
    end
    push_pl(8'h10, 4'd0);
    sendg(8'h10);
    push_pl(8'h20, 4'd1);
    sendg(8'h20);
    push_ok();
    send(8'h33);
    gap(1);
    checks++;
    if (bus.frame_ok !== 1'b1 || bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL good_pulse: ok=%b err=%b required ok=1 err=0", bus.frame_ok, bus.frame_err);
    end
    checks++;
    if (bus.cmd_out !== 8'h01 || bus.len_out !== 8'h02) begin
      errors++;
      $display("FAIL good_hdr: cmd=%h len=%h required 01 02", bus.cmd_out, bus.len_out);
    end
    drain("good");
  endtask
  task automatic test_zero_len;
    sendg(8'h55);
    sendg(8'h00);
    sendg(8'hAA);
    sendg(8'h05);
    sendg(8'h00);
    push_ok();
    send(8'h05);
    gap(1);
    checks++;
    if (bus.frame_ok !== 1'b1) begin
      errors++;
      $display("FAIL zero_pulse: ok=%b required 1", bus.frame_ok);
    end
    checks++;
    if (bus.cmd_out !== 8'h05 || bus.len_out !== 8'h00) begin
      errors++;
      $display("FAIL zero_hdr: cmd=%h len=%h required 05 00", bus.cmd_out, bus.len_out);
    end
    drain("zero");
  endtask
  task automatic test_bad_chk;
    sendg(8'hAA);
    sendg(8'h01);
    sendg(8'h02);
    push_pl(8'h10, 4'd0);
    sendg(8'h10);
    push_pl(8'h20, 4'd1);
    sendg(8'h20);
    push_err(ERR_CHK);
    send(8'h34);
    gap(1);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.err_code !== 2'b10 || bus.frame_ok !== 1'b0) begin
      errors++;
      $display("FAIL chk_pulse: err=%b code=%b ok=%b required 1 10 0",
               bus.frame_err, bus.err_code, bus.frame_ok);
    end
    drain("chk");
  endtask
  task automatic test_bad_len;
    sendg(8'hAA);
    sendg(8'h01);
    push_err(ERR_LEN);
    send(8'h11);
    gap(1);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.err_code !== 2'b01 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL len_pulse: err=%b code=%b busy=%b required 1 01 0",
               bus.frame_err, bus.err_code, bus.busy);
    end
    sendg(8'hAA);
    sendg(8'h02);
    sendg(8'h00);
    push_ok();
    send(8'h02);
    gap(1);
    checks++;
    if (bus.frame_ok !== 1'b1) begin
      errors++;
      $display("FAIL len_recover: ok=%b required 1", bus.frame_ok);
    end
    drain("len");
  endtask
  task automatic test_max_len;
    logic [7:0] c;
    logic [7:0] p;
    c = 8'h03 ^ 8'h10;
    sendg(8'hAA);
    sendg(8'h03);
    sendg(8'h10);
    for (int i = 0; i < 16; i++) begin
      p = 8'(i * 17 + 1);
      c = c ^ p;
      push_pl(p, 4'(i));
      sendg(p);
    end
    push_ok();
    send(c);
    gap(1);
    checks++;
    if (bus.frame_ok !== 1'b1) begin
      errors++;
      $display("FAIL maxlen_pulse: ok=%b required 1", bus.frame_ok);
    end
    drain("maxlen");
  endtask
  task automatic test_timeout;
    sendg(8'hAA);
    push_err(ERR_TMO);
    send(8'h01);
    for (int i = 1; i <= TMO + 1; i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      if (i >= TMO) begin
        checks++;
        if (bus.frame_err !== (i == TMO + 1)) begin
          errors++;
          $display("FAIL tmo_timing: cycle %0d err=%b required %b", i, bus.frame_err, i == TMO + 1);
        end
      end
    end
    checks++;
    if (bus.err_code !== 2'b11 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_code: code=%b busy=%b required 11 0", bus.err_code, bus.busy);
    end
    drain("tmo");
  endtask
  task automatic test_timeout_race;
    sendg(8'hAA);
    send(8'h01);
    gap(TMO - 1);
    send(8'h02);
    gap(1);
    checks++;
    if (bus.frame_err !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL race_nofire: err=%b busy=%b required 0 1", bus.frame_err, bus.busy);
    end
    push_pl(8'h10, 4'd0);
    sendg(8'h10);
    push_pl(8'h20, 4'd1);
    sendg(8'h20);
    push_ok();
    send(8'h33);
    gap(1);
    checks++;
    if (bus.frame_ok !== 1'b1) begin
      errors++;
      $display("FAIL race_ok: ok=%b required 1", bus.frame_ok);
    end
    drain("race");
  endtask
  task automatic test_reset_mid;
    sendg(8'hAA);
    sendg(8'h01);
    sendg(8'h02);
    push_pl(8'h10, 4'd0);
    send(8'h10);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    checks++;
    if ({bus.cmd_out, bus.len_out, bus.pl_data, bus.pl_valid, bus.pl_idx, bus.frame_ok,
         bus.frame_err, bus.err_code, bus.busy} !== 35'h0) begin
      errors++;
      $display("FAIL midreset_outputs: cmd=%h len=%h pl=%h code=%b busy=%b required all 0",
               bus.cmd_out, bus.len_out, bus.pl_data, bus.err_code, bus.busy);
    end
    drain("midreset");
  endtask
  task automatic test_back_to_back;
    send(8'hAA);
    send(8'h07);
    send(8'h02);
    push_pl(8'h01, 4'd0);
    send(8'h01);
    push_pl(8'h5A, 4'd1);
    send(8'h5A);
    push_ok();
    send(8'h5E);
    send(8'hAA);
    checks++;
    if (bus.frame_ok !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: ok=%b required 1", bus.frame_ok);
    end
    send(8'h09);
    send(8'h00);
    push_ok();
    send(8'h09);
    gap(1);
    checks++;
    if (bus.frame_ok !== 1'b1 || bus.cmd_out !== 8'h09) begin
      errors++;
      $display("FAIL b2b_second: ok=%b cmd=%h required 1 09", bus.frame_ok, bus.cmd_out);
    end
    drain("b2b");
  endtask
  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    test_reset();
    test_good_frame();
    test_zero_len();
    test_bad_chk();
    test_bad_len();
    test_max_len();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
